// File: rtl/rng_pkg.sv
// Shared types and constants for the round-robin RNG share controller.
// The step helper is 32 bits wide so any NUM_BITS up to 32 can reuse it.
package rng_pkg;

  typedef enum logic [0:0] {
    WARM  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [15:0] SEED_16 = 16'hACE1;

  // Galois right-shift step; a nonzero input never produces zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    return (s >> 1) ^ (s[0] ? taps : 32'd0);
  endfunction

endpackage

// File: rtl/rng_share_ctrl_rr_pick.sv
// Rotate-priority selector: the first set request at or above the pointer wins,
// wrapping past the top index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [PW-1:0]      o_idx
);

  logic w_found;

  always_comb begin
    w_found  = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(i_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && i_req[idx]) begin
        w_found       = 1'b1;
        o_onehot[idx] = 1'b1;
        o_idx         = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rng_share_ctrl.sv
// One LFSR word shared among NUM_REQ requesters by round-robin grant; each
// granted word is consumed, so no two requesters ever see the same draw.
module rng_share_ctrl
  import rng_pkg::*;
#(
  parameter int                  NUM_BITS     = 16,
  parameter int                  NUM_REQ      = 4,
  parameter int                  WARMUP       = 8,
  parameter logic [NUM_BITS-1:0] TAPS         = NUM_BITS'(TAPS_16),
  parameter logic [NUM_BITS-1:0] SEED_DEFAULT = NUM_BITS'(SEED_16)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_valid,
  input  logic [NUM_BITS-1:0] seed_data,
  output logic                seed_ready,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [NUM_BITS-1:0] rand_data,
  output logic                busy
);

  localparam int CW = $clog2(WARMUP + 1);
  localparam int PW = $clog2(NUM_REQ);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_ptr;
  logic [NUM_BITS-1:0] r_lfsr;

  logic                w_serve;
  logic                w_seed_fire;
  logic                w_any_req;
  logic [NUM_REQ-1:0]  w_onehot;
  logic [PW-1:0]       w_idx;
  logic [PW-1:0]       w_ptr_next;
  logic [NUM_BITS-1:0] w_lfsr_step;
  logic [NUM_BITS-1:0] w_seed_eff;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_serve     = (r_state == SERVE);
  assign w_seed_fire = w_serve && seed_valid;
  assign w_any_req   = |req;
  assign w_lfsr_step = NUM_BITS'(lfsr_step(32'(r_lfsr), 32'(TAPS)));
  assign w_seed_eff  = (seed_data == '0) ? SEED_DEFAULT : seed_data;
  assign w_ptr_next  = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  // A seed offered in SERVE always wins over requests in the same cycle.
  assign gnt        = (w_serve && !seed_valid) ? w_onehot : '0;
  assign seed_ready = w_serve;
  assign busy       = !w_serve;
  assign rand_data  = r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WARM;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_lfsr  <= SEED_DEFAULT;
    end else begin
      case (r_state)
        WARM: begin
          r_lfsr <= w_lfsr_step;
          if (r_cnt == CW'(WARMUP - 1)) begin
            r_state <= SERVE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SERVE: begin
          if (w_seed_fire) begin
            r_lfsr  <= w_seed_eff;
            r_cnt   <= '0;
            r_state <= WARM;
          end else if (w_any_req) begin
            r_lfsr <= w_lfsr_step;
            r_ptr  <= w_ptr_next;
          end
        end
        default: begin
          r_state <= WARM;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Self-checking bench: a reference model pushes expected outputs per cycle and
// each scenario task pops and compares them, plus fixed known-answer values.
`timescale 1ns/1ps
module tb_rng_share_ctrl;

  localparam int WARMUP = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_valid;
  logic [15:0] seed_data;
  logic        seed_ready;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [15:0] rand_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic [15:0] data;
    logic        busy;
  } exp_t;

  exp_t sb_q[$];

  // reference model state
  logic        m_serve;
  int          m_cnt;
  int          m_ptr;
  logic [15:0] m_lfsr;

  rng_share_ctrl #(
    .NUM_BITS (16),
    .NUM_REQ  (4),
    .WARMUP   (WARMUP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_data  (seed_data),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rand_data  (rand_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int m_pick(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_serve = 1'b0;
    m_cnt   = 0;
    m_ptr   = 0;
    m_lfsr  = 16'hACE1;
  endtask

  // Drive one cycle's inputs, push the model's expectation, move to mid-cycle.
  task automatic drive(input logic [3:0] r, input logic sv, input logic [15:0] sd);
    exp_t e;
    int   w;
    req        = r;
    seed_valid = sv;
    seed_data  = sd;
    w          = m_pick(r, m_ptr);
    e.gnt      = (m_serve && !sv && w >= 0) ? 4'(1 << w) : 4'b0000;
    e.data     = m_lfsr;
    e.busy     = !m_serve;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Apply the clock edge to the model and the DUT.
  task automatic advance();
    int w;
    if (!m_serve) begin
      m_lfsr = m_step(m_lfsr);
      if (m_cnt == WARMUP - 1) begin
        m_serve = 1'b1;
        m_cnt   = 0;
      end else begin
        m_cnt++;
      end
    end else if (seed_valid) begin
      m_lfsr  = (seed_data == 16'h0) ? 16'hACE1 : seed_data;
      m_serve = 1'b0;
      m_cnt   = 0;
    end else if (req != 4'b0) begin
      w      = m_pick(req, m_ptr);
      m_lfsr = m_step(m_lfsr);
      m_ptr  = (w + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req        = 4'b0;
    seed_valid = 1'b0;
    seed_data  = 16'h0;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req        = 4'b1111;
    seed_valid = 1'b1;
    seed_data  = 16'h1234;
    rst_n      = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    checks++;
    if (gnt !== 4'b0 || seed_ready !== 1'b0 || busy !== 1'b1 || rand_data !== 16'hACE1) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b seed_ready=%b busy=%b rand=%h required gnt=0000 seed_ready=0 busy=1 rand=ace1",
               gnt, seed_ready, busy, rand_data);
    end
    @(posedge clk);
    #1;
    req        = 4'b0;
    seed_valid = 1'b0;
    rst_n      = 1'b1;
    $display("test_reset: gnt=%b busy=%b rand=%h", gnt, busy, rand_data);
  endtask

  task automatic test_warmup();
    logic [15:0] words[4];
    logic [3:0]  gnts[4];
    exp_t        e;
    words = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
    gnts  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 1'b0, 16'h0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== e.gnt || rand_data !== e.data || busy !== e.busy) begin
        failures++;
        $display("FAIL warmup_model[%0d]: gnt=%b rand=%h busy=%b required gnt=%b rand=%h busy=%b",
                 i, gnt, rand_data, busy, e.gnt, e.data, e.busy);
      end
      checks++;
      if (gnt !== gnts[i] || rand_data !== words[i] || busy !== (i == 0)) begin
        failures++;
        $display("FAIL warmup_kat[%0d]: gnt=%b rand=%h busy=%b required gnt=%b rand=%h busy=%b",
                 i, gnt, rand_data, busy, gnts[i], words[i], (i == 0));
      end
      $display("test_warmup cycle %0d: gnt=%b rand=%h busy=%b", i, gnt, rand_data, busy);
      advance();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gnts[5];
    exp_t       e;
    gnts = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    drive(4'b0000, 1'b0, 16'h0);
    void'(sb_q.pop_front());
    advance();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 1'b0, 16'h0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== gnts[i] || gnt !== e.gnt || rand_data !== e.data) begin
        failures++;
        $display("FAIL round_robin[%0d]: gnt=%b rand=%h required gnt=%b rand=%h",
                 i, gnt, rand_data, gnts[i], e.data);
      end
      $display("test_round_robin grant %0d: gnt=%b rand=%h", i, gnt, rand_data);
      advance();
    end
    // idle cycle: LFSR and pointer must hold
    drive(4'b0000, 1'b0, 16'h0);
    e = sb_q.pop_front();
    checks++;
    if (gnt !== 4'b0 || rand_data !== e.data) begin
      failures++;
      $display("FAIL idle_hold: gnt=%b rand=%h required gnt=0000 rand=%h", gnt, rand_data, e.data);
    end
    $display("test_round_robin idle: gnt=%b rand=%h", gnt, rand_data);
    advance();
  endtask

  task automatic test_pointer_skip();
    logic [3:0] gnts[2];
    exp_t       e;
    gnts = '{4'b1000, 4'b0001};
    for (int i = 0; i < 2; i++) begin
      drive(4'b1001, 1'b0, 16'h0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== gnts[i] || gnt !== e.gnt || rand_data !== e.data) begin
        failures++;
        $display("FAIL pointer_skip[%0d]: gnt=%b rand=%h required gnt=%b rand=%h",
                 i, gnt, rand_data, gnts[i], e.data);
      end
      $display("test_pointer_skip %0d: gnt=%b rand=%h", i, gnt, rand_data);
      advance();
    end
  endtask

  task automatic seed_then_serve(input logic [15:0] sd, input string name);
    exp_t e;
    drive(4'b1111, 1'b1, sd);
    e = sb_q.pop_front();
    checks++;
    if (gnt !== 4'b0 || seed_ready !== 1'b1 || busy !== 1'b0 || rand_data !== e.data) begin
      failures++;
      $display("FAIL %s_accept: gnt=%b seed_ready=%b busy=%b rand=%h required gnt=0000 seed_ready=1 busy=0 rand=%h",
               name, gnt, seed_ready, busy, rand_data, e.data);
    end
    $display("%s accept: gnt=%b seed_ready=%b", name, gnt, seed_ready);
    advance();
    for (int i = 0; i < WARMUP; i++) begin
      drive(4'b1111, 1'b0, 16'h0);
      e = sb_q.pop_front();
      checks++;
      if (gnt !== 4'b0 || busy !== 1'b1 || seed_ready !== 1'b0 || rand_data !== e.data) begin
        failures++;
        $display("FAIL %s_warm[%0d]: gnt=%b busy=%b seed_ready=%b rand=%h required gnt=0000 busy=1 seed_ready=0 rand=%h",
                 name, i, gnt, busy, seed_ready, rand_data, e.data);
      end
      $display("%s warm %0d: busy=%b rand=%h", name, i, busy, rand_data);
      advance();
    end
    drive(4'b1111, 1'b0, 16'h0);
    e = sb_q.pop_front();
    checks++;
    if (gnt !== e.gnt || gnt === 4'b0 || rand_data !== 16'hE270 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_first_word: gnt=%b rand=%h busy=%b required gnt=%b rand=e270 busy=0",
               name, gnt, rand_data, busy, e.gnt);
    end
    $display("%s first word: gnt=%b rand=%h", name, gnt, rand_data);
    advance();
  endtask

  task automatic test_seed_priority();
    seed_then_serve(16'hACE1, "seed_priority");
  endtask

  task automatic test_zero_seed();
    exp_t e;
    int   bad_zero;
    int   bad_model;
    seed_then_serve(16'h0000, "zero_seed");
    bad_zero  = 0;
    bad_model = 0;
    for (int i = 0; i < 65600; i++) begin
      drive(4'b1111, 1'b0, 16'h0);
      e = sb_q.pop_front();
      if (rand_data === 16'h0) bad_zero++;
      if (rand_data !== e.data || gnt !== e.gnt) bad_model++;
      advance();
    end
    checks++;
    if (bad_zero != 0) begin
      failures++;
      $display("FAIL lfsr_nonzero: zero_cycles=%0d required 0", bad_zero);
    end
    checks++;
    if (bad_model != 0) begin
      failures++;
      $display("FAIL long_run_model: mismatched_cycles=%0d required 0", bad_model);
    end
    $display("test_zero_seed long run: zero_cycles=%0d model_diffs=%0d", bad_zero, bad_model);
  endtask

  task automatic test_reset_mid_warm();
    exp_t e;
    do_reset();
    drive(4'b0000, 1'b0, 16'h0);
    void'(sb_q.pop_front());
    advance();
    drive(4'b0000, 1'b1, 16'h1234);
    void'(sb_q.pop_front());
    advance();
    // now in WARM holding the new seed; pull reset between edges
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0 || seed_ready !== 1'b0 || busy !== 1'b1 || rand_data !== 16'hACE1) begin
      failures++;
      $display("FAIL mid_warm_reset: gnt=%b seed_ready=%b busy=%b rand=%h required gnt=0000 seed_ready=0 busy=1 rand=ace1",
               gnt, seed_ready, busy, rand_data);
    end
    $display("test_reset_mid_warm async: busy=%b rand=%h", busy, rand_data);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(4'b0010, 1'b0, 16'h0);
    e = sb_q.pop_front();
    checks++;
    if (busy !== 1'b1 || gnt !== 4'b0 || rand_data !== e.data) begin
      failures++;
      $display("FAIL mid_warm_restart: busy=%b gnt=%b rand=%h required busy=1 gnt=0000 rand=%h",
               busy, gnt, rand_data, e.data);
    end
    advance();
    drive(4'b0010, 1'b0, 16'h0);
    e = sb_q.pop_front();
    checks++;
    if (gnt !== 4'b0010 || rand_data !== 16'hE270 || gnt !== e.gnt) begin
      failures++;
      $display("FAIL mid_warm_first_word: gnt=%b rand=%h required gnt=0010 rand=e270", gnt, rand_data);
    end
    $display("test_reset_mid_warm first word: gnt=%b rand=%h", gnt, rand_data);
    advance();
  endtask

  initial begin
    rst_n      = 1'b0;
    req        = 4'b0;
    seed_valid = 1'b0;
    seed_data  = 16'h0;
    model_reset();
    test_reset();
    test_warmup();
    test_round_robin();
    test_pointer_skip();
    test_seed_priority();
    test_zero_seed();
    test_reset_mid_warm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
